// File: rtl/mux_nx1_stream.sv
// Registered N-to-1 stream multiplexer with valid/ready handshake and packet lock.
// Channel choice is either an external index (mode 0) or round-robin (mode 1).
// Once a multi-beat packet starts, its channel is held until the last beat is accepted.
module mux_nx1_stream #(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_chan,
  input  logic                    out_ready
);

  typedef enum logic {
    S_OPEN = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] rr_last;
  logic [SEL_W-1:0] cur_c;
  logic [SEL_W-1:0] cand_c;
  logic             cur_vld_c;
  logic             load_c;
  logic             accept_c;

  // Output stage can take a beat when empty or when its current beat leaves.
  assign load_c   = !out_valid || out_ready;
  assign accept_c = cur_vld_c && load_c && in_valid[cur_c];

  // Current channel: held grant while locked, else sel or round-robin search.
  always_comb begin
    cur_c     = '0;
    cur_vld_c = 1'b0;
    cand_c    = '0;
    if (state == S_LOCK) begin
      cur_c     = grant;
      cur_vld_c = 1'b1;
    end else if (!mode) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (sel == SEL_W'(i)) begin
          cur_c     = sel;
          cur_vld_c = 1'b1;
        end
      end
    end else begin
      // Descending scan so the nearest channel after rr_last is the one kept.
      for (int k = int'(NUM_CH); k >= 1; k--) begin
        cand_c = SEL_W'((32'(rr_last) + 32'(k)) % NUM_CH);
        if (in_valid[cand_c]) begin
          cur_c     = cand_c;
          cur_vld_c = 1'b1;
        end
      end
    end
  end

  // Only the current channel may see ready, and only when the output can load.
  always_comb begin
    in_ready = '0;
    if (cur_vld_c && load_c) begin
      in_ready[cur_c] = 1'b1;
    end
  end

  // Lock is entered on a non-last beat and released on the last beat.
  always_comb begin
    state_nxt = state;
    if (accept_c) begin
      state_nxt = in_last[cur_c] ? S_OPEN : S_LOCK;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OPEN;
    end else begin
      state <= state_nxt;
    end
  end

  // Output register plus grant and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
      grant     <= '0;
      rr_last   <= SEL_W'(NUM_CH - 1);
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_data  <= in_data[cur_c*WIDTH +: WIDTH];
      out_last  <= in_last[cur_c];
      out_chan  <= cur_c;
      grant     <= cur_c;
      rr_last   <= cur_c;
    end else if (load_c) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Self-checking bench for mux_nx1_stream: directed handshake scenarios with a
// scoreboard of expected output beats, plus a 3-channel instance for out-of-range sel.
module tb_mux_nx1_stream;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] c;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_chan;
  logic        out_ready;

  logic [23:0] in3_data;
  logic [2:0]  in3_valid;
  logic [2:0]  in3_last;
  logic [2:0]  in3_ready;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out3_data;
  logic        out3_valid;
  logic        out3_last;
  logic [1:0]  out3_chan;
  logic        out3_ready;

  int    n_checks;
  int    n_fail;
  beat_t sb_q[$];

  mux_nx1_stream #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  mux_nx1_stream #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(in3_data), .in_valid(in3_valid), .in_last(in3_last), .in_ready(in3_ready),
    .mode(mode3), .sel(sel3),
    .out_data(out3_data), .out_valid(out3_valid), .out_last(out3_last), .out_chan(out3_chan),
    .out_ready(out3_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d, input logic l, input logic v);
    in_data[ch*8 +: 8] = d;
    in_last[ch]        = l;
    in_valid[ch]       = v;
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic [1:0] c);
    beat_t b;
    b.d = d;
    b.l = l;
    b.c = c;
    sb_q.push_back(b);
  endtask

  // Scoreboard: every beat leaving the main instance must match the next expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        check("sb_data", 32'(out_data), 32'(e.d));
        check("sb_last", 32'(out_last), 32'(e.l));
        check("sb_chan", 32'(out_chan), 32'(e.c));
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    in_data    = '0;
    in_valid   = '0;
    in_last    = '0;
    mode       = 1'b0;
    sel        = 2'd2;
    out_ready  = 1'b1;
    in3_data   = '0;
    in3_valid  = '0;
    in3_last   = '0;
    mode3      = 1'b0;
    sel3       = 2'd0;
    out3_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_chan", 32'(out_chan), 32'd0);
    #9 rst = 1'b0;
    tick();

    // 1: fixed sel=2, two-beat packet at full rate
    set_ch(2, 8'h11, 1'b0, 1'b1);
    #1;
    check("t1_in_ready_a", 32'(in_ready), 32'b0100);
    push(8'h11, 1'b0, 2'd2);
    tick();
    check("t1_first_data", 32'(out_data), 32'h11);
    set_ch(2, 8'h22, 1'b1, 1'b1);
    #1;
    check("t1_in_ready_b", 32'(in_ready), 32'b0100);
    push(8'h22, 1'b1, 2'd2);
    tick();
    set_ch(2, 8'h00, 1'b0, 1'b0);
    check("t1_second_data", 32'(out_data), 32'h22);
    check("t1_second_last", 32'(out_last), 32'd1);
    check("t1_second_chan", 32'(out_chan), 32'd2);
    tick();
    tick();

    // 2: lock holds ch1 across a sel change and an idle cycle
    sel = 2'd1;
    set_ch(1, 8'hA0, 1'b0, 1'b1);
    #1;
    check("t2_ready_start", 32'(in_ready), 32'b0010);
    push(8'hA0, 1'b0, 2'd1);
    tick();
    sel = 2'd3;
    set_ch(1, 8'h00, 1'b0, 1'b0);
    set_ch(3, 8'hD0, 1'b1, 1'b1);
    #1;
    check("t2_ready_locked_a", 32'(in_ready), 32'b0010);
    tick();
    check("t2_ready_locked_b", 32'(in_ready), 32'b0010);
    set_ch(1, 8'hA1, 1'b1, 1'b1);
    #1;
    check("t2_ready_locked_c", 32'(in_ready), 32'b0010);
    push(8'hA1, 1'b1, 2'd1);
    tick();
    set_ch(1, 8'h00, 1'b0, 1'b0);
    #1;
    check("t2_ready_after_last", 32'(in_ready), 32'b1000);
    push(8'hD0, 1'b1, 2'd3);
    tick();
    set_ch(3, 8'h00, 1'b0, 1'b0);
    tick();
    tick();

    // 3: round-robin over four always-valid single-beat channels
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ch(i, 8'h30 + 8'(i), 1'b1, 1'b1);
    end
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t3_ready_onehot", 32'(in_ready), 32'(1 << (k % 4)));
      push(8'h30 + 8'(k % 4), 1'b1, 2'(k % 4));
      tick();
    end
    in_valid = '0;
    in_last  = '0;
    tick();
    tick();

    // 4: backpressure with a locked two-beat packet on ch1
    set_ch(1, 8'h41, 1'b0, 1'b1);
    #1;
    check("t4_ready_first", 32'(in_ready), 32'b0010);
    push(8'h41, 1'b0, 2'd1);
    tick();
    out_ready = 1'b0;
    set_ch(1, 8'h42, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_stall_ready", 32'(in_ready), 32'd0);
      check("t4_stall_valid", 32'(out_valid), 32'd1);
      check("t4_stall_data", 32'(out_data), 32'h41);
      check("t4_stall_last", 32'(out_last), 32'd0);
      check("t4_stall_chan", 32'(out_chan), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t4_ready_resume", 32'(in_ready), 32'b0010);
    push(8'h42, 1'b1, 2'd1);
    tick();
    set_ch(1, 8'h00, 1'b0, 1'b0);
    check("t4_resume_data", 32'(out_data), 32'h42);
    tick();
    tick();

    // 5: out-of-range sel on the 3-channel instance accepts nothing
    in3_data  = 24'hC2C1C0;
    in3_valid = 3'b111;
    in3_last  = 3'b111;
    sel3      = 2'd3;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("t5_ready_oor", 32'(in3_ready), 32'd0);
      tick();
      check("t5_valid_oor", 32'(out3_valid), 32'd0);
    end
    sel3 = 2'd2;
    #1;
    check("t5_ready_inrange", 32'(in3_ready), 32'b100);
    tick();
    in3_valid = '0;
    check("t5_out_valid", 32'(out3_valid), 32'd1);
    check("t5_out_data", 32'(out3_data), 32'hC2);
    check("t5_out_chan", 32'(out3_chan), 32'd2);
    tick();

    // 6: reset in the middle of a locked packet drops it; ch0 wins first after release
    set_ch(2, 8'h61, 1'b0, 1'b1);
    #1;
    push(8'h61, 1'b0, 2'd2);
    tick();
    check("t6_pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_last", 32'(out_last), 32'd0);
    check("t6_rst_chan", 32'(out_chan), 32'd0);
    set_ch(0, 8'h70, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_ready_ch0_first", 32'(in_ready), 32'b0001);
    push(8'h70, 1'b1, 2'd0);
    tick();
    in_valid = '0;
    in_last  = '0;
    check("t6_out_chan", 32'(out_chan), 32'd0);
    tick();
    tick();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
